// File: rtl/pc_fetch_unit_if.sv
// Fetch-side channels: instruction-memory request/response and the decode handoff.
// The master modport is the fetch unit; the slave modport is the memory/decode side.
interface pc_fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [15:0] imm16;
  logic [25:0] target;

  modport master (
    output imem_req_valid,
    input  imem_req_ready,
    output imem_addr,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    output inst_valid,
    input  inst_ready,
    output inst,
    output inst_pc,
    output imm16,
    output target
  );

  modport slave (
    input  imem_req_valid,
    output imem_req_ready,
    input  imem_addr,
    output imem_rsp_valid,
    output imem_rsp_data,
    input  inst_valid,
    output inst_ready,
    input  inst,
    input  inst_pc,
    input  imm16,
    input  target
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Multi-cycle PC register and instruction fetcher: one outstanding imem read, decode handoff.
// Define PCFETCH_ALIGN_CHECK_EN to trap misaligned next_pc into a sticky fault/HALT state.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              next_pc,
  output logic                     fault,
  pc_fetch_unit_if.master          bus
);

  typedef enum logic [1:0] {StReq, StWait, StHold, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;

`ifdef PCFETCH_ALIGN_CHECK_EN
  logic fault_q, fault_d;
`else
  // Low bits are discarded when alignment checking is compiled out.
  logic unused_next_pc_lsb;
  assign unused_next_pc_lsb = ^next_pc[1:0];
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
`ifdef PCFETCH_ALIGN_CHECK_EN
    fault_d   = fault_q;
`endif
    unique case (state_q)
      StReq: begin
        if (bus.imem_req_ready) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (bus.imem_rsp_valid) begin
          inst_d    = bus.imem_rsp_data;
          inst_pc_d = pc_q;
          state_d   = StHold;
        end
      end
      StHold: begin
        if (bus.inst_ready) begin
`ifdef PCFETCH_ALIGN_CHECK_EN
          pc_d = next_pc;
          if (next_pc[1:0] != 2'b00) begin
            fault_d = 1'b1;
            state_d = StHalt;
          end else begin
            state_d = StReq;
          end
`else
          pc_d    = {next_pc[31:2], 2'b00};
          state_d = StReq;
`endif
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StReq;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StReq;
      pc_q      <= RESET_PC;
      inst_q    <= 32'h0;
      inst_pc_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

`ifdef PCFETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  // Request is masked during the reset cycle itself, even though state already reads StReq.
  assign bus.imem_req_valid = (state_q == StReq) && !rst;
  assign bus.imem_addr      = pc_q;
  assign bus.inst_valid     = (state_q == StHold);
  assign bus.inst           = inst_q;
  assign bus.inst_pc        = inst_pc_q;
  assign bus.imm16          = inst_q[15:0];
  assign bus.target         = inst_q[25:0];

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed table-driven bench for pc_fetch_unit, plus reset, wrap and misalignment sequences.
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] next_pc;
  logic        fault;

  pc_fetch_unit_if bus ();

  pc_fetch_unit #(
    .RESET_PC(32'h0000_3000)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .next_pc(next_pc),
    .fault  (fault),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          req_stall;
    int          rsp_delay;
    logic [31:0] data;
    int          dec_stall;
    logic [31:0] npc;
    logic [31:0] exp_addr;
    logic [15:0] exp_imm;
    logic [25:0] exp_target;
  } vec_t;

  vec_t vecs[5];
  int   n_chk;
  int   n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.inst_ready = 1'b0;
    @(negedge clk);
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
    chk("rst_inst_valid", 32'(bus.inst_valid), 32'h0);
    chk("rst_inst", bus.inst, 32'h0);
    chk("rst_inst_pc", bus.inst_pc, 32'h0);
    chk("rst_imm16", 32'(bus.imm16), 32'h0);
    chk("rst_target", 32'(bus.target), 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_valid", 32'(bus.imem_req_valid), 32'h1);
    chk("post_rst_addr", bus.imem_addr, 32'h0000_3000);
  endtask

  // Starts and ends at a negedge with the DUT in REQ.
  task automatic fetch(input vec_t v);
    for (int i = 0; i < v.req_stall; i++) begin
      chk("stall_req_valid", 32'(bus.imem_req_valid), 32'h1);
      chk("stall_addr", bus.imem_addr, v.exp_addr);
      chk("stall_inst_valid", 32'(bus.inst_valid), 32'h0);
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b1;  // stray response in REQ must be ignored
      bus.imem_rsp_data  = 32'hBAD0_BAD0;
      @(negedge clk);
    end
    chk("req_valid", 32'(bus.imem_req_valid), 32'h1);
    chk("req_addr", bus.imem_addr, v.exp_addr);
    chk("req_inst_valid", 32'(bus.inst_valid), 32'h0);
    bus.imem_rsp_valid = 1'b0;
    bus.imem_req_ready = 1'b1;
    @(negedge clk);
    bus.imem_req_ready = 1'b0;
    chk("wait_req_valid", 32'(bus.imem_req_valid), 32'h0);
    for (int i = 0; i < v.rsp_delay; i++) begin
      @(negedge clk);
      chk("wait_inst_valid", 32'(bus.inst_valid), 32'h0);
      chk("wait_no_req", 32'(bus.imem_req_valid), 32'h0);
    end
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = v.data;
    @(negedge clk);
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h5A5A_5A5A;
    for (int i = 0; i <= v.dec_stall; i++) begin
      chk("hold_inst_valid", 32'(bus.inst_valid), 32'h1);
      chk("hold_inst", bus.inst, v.data);
      chk("hold_inst_pc", bus.inst_pc, v.exp_addr);
      chk("hold_imm16", 32'(bus.imm16), 32'(v.exp_imm));
      chk("hold_target", 32'(bus.target), 32'(v.exp_target));
      chk("hold_no_req", 32'(bus.imem_req_valid), 32'h0);
      if (i < v.dec_stall) begin
        bus.inst_ready = 1'b0;
        @(negedge clk);
      end
    end
    bus.inst_ready = 1'b1;
    next_pc = v.npc;
    @(negedge clk);
    bus.inst_ready = 1'b0;
    next_pc = 32'hA5A5_A5A5;
    chk("post_hs_inst_valid", 32'(bus.inst_valid), 32'h0);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst = 1'b1;
    next_pc = 32'h0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.inst_ready     = 1'b0;

    vecs[0] = '{0, 0, 32'h2008_0005, 0, 32'h0000_3004, 32'h0000_3000, 16'h0005, 26'h008_0005};
    vecs[1] = '{3, 2, 32'hDEAD_BEEF, 4, 32'h0000_3040, 32'h0000_3004, 16'hBEEF, 26'h2AD_BEEF};
    vecs[2] = '{1, 0, 32'h0000_0000, 1, 32'hFFFF_FFFC, 32'h0000_3040, 16'h0000, 26'h000_0000};
    vecs[3] = '{0, 1, 32'hFFFF_FFFF, 0, 32'h0000_0000, 32'hFFFF_FFFC, 16'hFFFF, 26'h3FF_FFFF};
    vecs[4] = '{0, 0, 32'h1234_5678, 2, 32'h0000_3006, 32'h0000_0000, 16'h5678, 26'h234_5678};

    @(negedge clk);
    do_reset();

    for (int k = 0; k < 5; k++) begin
      fetch(vecs[k]);
    end

`ifdef PCFETCH_ALIGN_CHECK_EN
    bus.imem_req_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("halt_fault", 32'(fault), 32'h1);
      chk("halt_no_req", 32'(bus.imem_req_valid), 32'h0);
      chk("halt_inst_valid", 32'(bus.inst_valid), 32'h0);
      @(negedge clk);
    end
    bus.imem_req_ready = 1'b0;
`else
    chk("misalign_addr", bus.imem_addr, 32'h0000_3004);
    chk("misalign_req_valid", 32'(bus.imem_req_valid), 32'h1);
    chk("misalign_fault", 32'(fault), 32'h0);
`endif

    // Reset while WAIT is outstanding with pc=3040.
    do_reset();
    fetch('{0, 0, 32'h0000_0001, 0, 32'h0000_3040, 32'h0000_3000, 16'h0001, 26'h000_0001});
    chk("midwait_addr", bus.imem_addr, 32'h0000_3040);
    bus.imem_req_ready = 1'b1;
    @(negedge clk);
    bus.imem_req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midwait_rst_inst_valid", 32'(bus.inst_valid), 32'h0);
    chk("midwait_rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
    chk("midwait_rst_fault", 32'(fault), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("midwait_post_req_valid", 32'(bus.imem_req_valid), 32'h1);
    chk("midwait_post_addr", bus.imem_addr, 32'h0000_3000);
    chk("midwait_post_inst_valid", 32'(bus.inst_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
